frame_swap_ctrl: RTL and testbench

System-domain controller that sequences double-buffered rendering: it starts the renderer on the back buffer, waits for the renderer to finish, then swaps front/back at the next vertical blank. It drives `front_sel_sys` and `swap_tick_sys` into the frame-swap mux stage that steers VRAM A/B ports. It synchronizes the pixel-domain vblank level internally. It also counts presented frames and missed deadlines.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/frame_swap_ctrl_if.sv | 34 +++
 rtl/Synch2FF.sv | 32 +++
 rtl/frame_swap_ctrl.sv | 116 +++++++++++
 tb/tb_frame_swap_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and default sizes for the frame-buffer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

   localparam int c_CNT_W_DEF         = 16;
   localparam int c_SETTLE_CYCLES_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RENDER  = 3'd1,
      ST_WAIT_VB = 3'd2,
      ST_SWAP    = 3'd3,
      ST_SETTLE  = 3'd4
   } swap_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_swap_ctrl_if.sv
// ============================================================================
// Module      : frame_swap_ctrl_if
// Description : Renderer handshake and swap-status bundle of frame_swap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_swap_ctrl_if
   import fb_pkg::*;
#(
   parameter int CNT_W = c_CNT_W_DEF
);
   logic             render_start;
   logic             render_busy;
   logic             render_done;
   logic             front_sel_sys;
   logic             swap_tick_sys;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] miss_cnt;

   modport master (
      output render_start, render_busy, front_sel_sys, swap_tick_sys,
             frame_cnt, miss_cnt,
      input  render_done
   );

   modport slave (
      input  render_start, render_busy, front_sel_sys, swap_tick_sys,
             frame_cnt, miss_cnt,
      output render_done
   );
endinterface

`default_nettype wire

// File: rtl/Synch2FF.sv
// ============================================================================
// Module      : Synch2FF
// Description : Two-flop synchronizer for level signals crossing into clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Synch2FF #(
   parameter int Data_W = 1
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic [Data_W-1:0] din,
   output logic      [Data_W-1:0] dout
);
   logic [Data_W-1:0] r_meta;
   logic [Data_W-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= din;
         r_sync <= r_meta;
      end
   end

   assign dout = r_sync;
endmodule

`default_nettype wire

// File: rtl/frame_swap_ctrl.sv
// ============================================================================
// Module      : frame_swap_ctrl
// Description : Sequences render / wait-vblank / swap / settle for a
//               double-buffered display and counts frames and misses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_swap_ctrl
   import fb_pkg::*;
#(
   parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEF,
   parameter int CNT_W         = c_CNT_W_DEF
) (
   input  wire logic         clk_sys,
   input  wire logic         srst_n,
   input  wire logic         enable,
   input  wire logic         vblank_async,
   frame_swap_ctrl_if.master bus
);
   localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   swap_state_t      r_state, w_state_nxt;
   logic [7:0]       r_settle, w_settle_nxt;
   logic             w_vb_s, r_vb_d, w_vb_rise;
   logic             r_render_start, r_render_busy, r_front_sel, r_swap_tick;
   logic [CNT_W-1:0] r_frame_cnt, r_miss_cnt;
   logic             w_start_nxt, w_busy_nxt, w_swap_nxt, w_miss_inc;
   logic [CNT_W-1:0] w_frame_nxt, w_miss_nxt;

   Synch2FF #(.Data_W(1)) u_vb_sync (
      .clk   (clk_sys),
      .rst_n (srst_n),
      .din   (vblank_async),
      .dout  (w_vb_s)
   );

   assign w_vb_rise = w_vb_s & ~r_vb_d;

   always_ff @(posedge clk_sys or negedge srst_n) begin
      if (!srst_n) begin
         r_state  <= ST_IDLE;
         r_settle <= '0;
         r_vb_d   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_settle <= w_settle_nxt;
         r_vb_d   <= w_vb_s;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = r_settle;
      unique case (r_state)
         ST_IDLE: begin
            if (enable) w_state_nxt = ST_RENDER;
         end
         ST_RENDER: begin
            // A rise landing with render_done is consumed by the swap.
            if (bus.render_done && w_vb_rise) w_state_nxt = ST_SWAP;
            else if (bus.render_done)         w_state_nxt = ST_WAIT_VB;
         end
         ST_WAIT_VB: begin
            if (w_vb_rise) w_state_nxt = ST_SWAP;
         end
         ST_SWAP: begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = c_SETTLE_LOAD;
         end
         ST_SETTLE: begin
            if (r_settle == 8'd0) w_state_nxt = enable ? ST_RENDER : ST_IDLE;
            else                  w_settle_nxt = r_settle - 8'd1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed from the transition and registered with the state.
   always_comb begin
      w_start_nxt = (w_state_nxt == ST_RENDER) && (r_state != ST_RENDER);
      w_busy_nxt  = (w_state_nxt == ST_RENDER);
      w_swap_nxt  = (w_state_nxt == ST_SWAP) && (r_state != ST_SWAP);
      w_miss_inc  = (r_state == ST_RENDER) && w_vb_rise && !bus.render_done;
      w_frame_nxt = r_frame_cnt + CNT_W'(w_swap_nxt);
      w_miss_nxt  = (w_miss_inc && (r_miss_cnt != '1)) ? r_miss_cnt + CNT_W'(1)
                                                         : r_miss_cnt;
   end

   always_ff @(posedge clk_sys or negedge srst_n) begin
      if (!srst_n) begin
         r_render_start <= 1'b0;
         r_render_busy  <= 1'b0;
         r_front_sel    <= 1'b0;
         r_swap_tick    <= 1'b0;
         r_frame_cnt    <= '0;
         r_miss_cnt     <= '0;
      end else begin
         r_render_start <= w_start_nxt;
         r_render_busy  <= w_busy_nxt;
         r_front_sel    <= r_front_sel ^ w_swap_nxt;
         r_swap_tick    <= w_swap_nxt;
         r_frame_cnt    <= w_frame_nxt;
         r_miss_cnt     <= w_miss_nxt;
      end
   end

   assign bus.render_start  = r_render_start;
   assign bus.render_busy   = r_render_busy;
   assign bus.front_sel_sys = r_front_sel;
   assign bus.swap_tick_sys = r_swap_tick;
   assign bus.frame_cnt     = r_frame_cnt;
   assign bus.miss_cnt      = r_miss_cnt;
endmodule

`default_nettype wire

// File: tb/tb_frame_swap_ctrl.sv
// ============================================================================
// Module      : tb_frame_swap_ctrl
// Description : Directed table plus corner sequences for frame_swap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_frame_swap_ctrl;
   // Narrow counters so wrap and saturation are reachable quickly.
   localparam int CNT_W  = 2;
   localparam int SETTLE = 4;

   logic clk_sys      = 1'b0;
   logic srst_n       = 1'b0;
   logic enable       = 1'b0;
   logic vblank_async = 1'b0;

   int total = 0;
   int bad   = 0;

   frame_swap_ctrl_if #(.CNT_W(CNT_W)) bus ();

   frame_swap_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
      .clk_sys      (clk_sys),
      .srst_n       (srst_n),
      .enable       (enable),
      .vblank_async (vblank_async),
      .bus          (bus.master)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic en, vb, done;
      int   n;
      logic start, busy, front, tick;
      int   frame, miss;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic en, vb, done, input int n,
                      input logic start, busy, front, tick, input int frame, miss);
      vec_t v;
      v.en = en; v.vb = vb; v.done = done; v.n = n;
      v.start = start; v.busy = busy; v.front = front; v.tick = tick;
      v.frame = frame; v.miss = miss;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic start, busy, front, swp,
                          input int frame, miss);
      chk({tag, "_start"}, int'(bus.render_start),  int'(start));
      chk({tag, "_busy"},  int'(bus.render_busy),   int'(busy));
      chk({tag, "_front"}, int'(bus.front_sel_sys), int'(front));
      chk({tag, "_tick"},  int'(bus.swap_tick_sys), int'(swp));
      chk({tag, "_frame"}, int'(bus.frame_cnt),     frame);
      chk({tag, "_miss"},  int'(bus.miss_cnt),      miss);
   endtask

   // which: 0 = swap_tick_sys, 1 = render_start
   task automatic wait_sig(input string name, input int which, input int budget,
                           output int cycles);
      cycles = 0;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if ((which == 0) ? bus.swap_tick_sys : bus.render_start) begin
            cycles = i;
            return;
         end
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bus.render_done = 1'b0;
      enable          = 1'b1;

      //   en vb dn  n  st bs fr tk frm mis
      add(1, 0, 0,  1, 1, 1, 0, 0, 0, 0);
      add(1, 0, 0,  1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 0, 10, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0,  5, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0,  1, 0, 0, 1, 1, 1, 0);
      add(1, 1, 0,  1, 0, 0, 1, 0, 1, 0);
      add(1, 1, 0,  3, 0, 0, 1, 0, 1, 0);
      add(1, 1, 0,  1, 1, 1, 1, 0, 1, 0);
      add(1, 0, 0,  3, 0, 1, 1, 0, 1, 0);
      add(1, 1, 0,  3, 0, 1, 1, 0, 1, 1);
      add(1, 0, 0,  3, 0, 1, 1, 0, 1, 1);
      add(1, 1, 0,  3, 0, 1, 1, 0, 1, 2);
      add(1, 0, 0,  3, 0, 1, 1, 0, 1, 2);
      add(1, 1, 0,  3, 0, 1, 1, 0, 1, 3);
      add(1, 0, 0,  3, 0, 1, 1, 0, 1, 3);
      add(1, 1, 0,  3, 0, 1, 1, 0, 1, 3);
      add(1, 0, 0,  3, 0, 1, 1, 0, 1, 3);
      add(1, 1, 0,  2, 0, 1, 1, 0, 1, 3);
      add(1, 1, 1,  1, 0, 0, 0, 1, 2, 3);
      add(1, 1, 0,  1, 0, 0, 0, 0, 2, 3);
      add(0, 1, 0,  4, 0, 0, 0, 0, 2, 3);
      add(0, 1, 0,  5, 0, 0, 0, 0, 2, 3);
      add(1, 1, 0,  1, 1, 1, 0, 0, 2, 3);
      add(0, 1, 0,  2, 0, 1, 0, 0, 2, 3);
      add(0, 1, 1,  1, 0, 0, 0, 0, 2, 3);
      add(0, 0, 0,  3, 0, 0, 0, 0, 2, 3);
      add(0, 1, 0,  2, 0, 0, 0, 0, 2, 3);
      add(0, 1, 0,  1, 0, 0, 1, 1, 3, 3);
      add(0, 1, 0,  5, 0, 0, 1, 0, 3, 3);
      add(0, 1, 0,  4, 0, 0, 1, 0, 3, 3);

      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk_sys);
      #1 srst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         enable          = vecs[i].en;
         vblank_async    = vecs[i].vb;
         bus.render_done = vecs[i].done;
         for (int c = 0; c < vecs[i].n; c++) tick();
         chk_all($sformatf("v%0d", i), vecs[i].start, vecs[i].busy, vecs[i].front,
                 vecs[i].tick, vecs[i].frame, vecs[i].miss);
      end
      bus.render_done = 1'b0;

      // Restart from IDLE, then a swap that wraps frame_cnt 3 -> 0.
      enable = 1'b1;
      tick();
      chk("restart_start", int'(bus.render_start), 1);
      bus.render_done = 1'b1;
      tick();
      bus.render_done = 1'b0;
      vblank_async = 1'b0;
      repeat (3) tick();
      vblank_async = 1'b1;
      wait_sig("swap_wrap", 0, 8, cyc);
      chk("swap_wrap_lat",   cyc, 3);
      chk("swap_wrap_front", int'(bus.front_sel_sys), 0);
      chk("swap_wrap_frame", int'(bus.frame_cnt), 0);
      wait_sig("settle_gap", 1, 10, cyc);
      chk("settle_gap_len", cyc, 1 + SETTLE);

      // Second swap puts B in front, then reset hits during SETTLE.
      bus.render_done = 1'b1;
      tick();
      bus.render_done = 1'b0;
      vblank_async = 1'b0;
      repeat (3) tick();
      vblank_async = 1'b1;
      wait_sig("swap_b", 0, 8, cyc);
      chk("swap_b_front", int'(bus.front_sel_sys), 1);
      chk("swap_b_frame", int'(bus.frame_cnt), 1);
      tick();
      tick();
      #2 srst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("rst_hold%0d_tick", c),  int'(bus.swap_tick_sys), 0);
         chk($sformatf("rst_hold%0d_front", c), int'(bus.front_sel_sys), 0);
      end
      enable       = 1'b0;
      vblank_async = 1'b0;
      srst_n       = 1'b1;
      repeat (3) tick();
      chk_all("post_rst_idle", 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
